// File: rtl/lht_pkg.sv
// Shared fetch-unit constants for the local history table. The clear FSM
// encoding and the PC-to-index helper also live here.
package lht_pkg;

  localparam int PC_WIDTH    = 64;
  localparam int PC_LSB      = 2;
  localparam int LOG_LHT     = 10;
  localparam int LHT_ENTRIES = 1 << LOG_LHT;
  // Must match the PHT's LOG_INDEX: the history is used directly as its index.
  localparam int HIST_WIDTH  = 10;
  localparam int CLR_ROWS    = 32;
  localparam int CLR_ROW_W   = $clog2(CLR_ROWS);
  localparam int CLR_STEPS   = LHT_ENTRIES / CLR_ROWS;
  localparam int CLR_CNT_W   = $clog2(CLR_STEPS);

  localparam logic [CLR_CNT_W-1:0] CLR_LAST = CLR_CNT_W'(CLR_STEPS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } lht_state_e;

  // Select the table entry addressed by an instruction PC.
  function automatic logic [LOG_LHT-1:0] lht_index(input logic [PC_WIDTH-1:0] pc);
    return pc[PC_LSB+LOG_LHT-1:PC_LSB];
  endfunction

endpackage

// File: rtl/lht.sv
// Local history table: per-PC branch histories feeding the local PHT.
// Fetch reads a registered history; commit shifts in resolved directions and
// forwards the pre-update history to the PHT write port one cycle later.
module lht
  import lht_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  lht_rd_valid_i,
  input  logic [PC_WIDTH-1:0]   lht_rd_pc_i,
  output logic                  lht_rd_ready_o,
  input  logic                  lht_stall_i,
  input  logic                  lht_flush_i,
  output logic                  lht_rd_valid_o,
  output logic [HIST_WIDTH-1:0] lht_pht_rd_index_o,
  input  logic                  lht_cm_valid_i,
  input  logic [PC_WIDTH-1:0]   lht_cm_pc_i,
  input  logic                  lht_cm_brdir_i,
  output logic                  lht_cm_ready_o,
  output logic                  lht_pht_we_o,
  output logic [HIST_WIDTH-1:0] lht_pht_wt_index_o,
  output logic                  lht_pht_brdir_o,
  input  logic                  lht_clear_i,
  output logic                  lht_clear_busy_o
);

  lht_state_e             state_q, state_d;
  logic [CLR_CNT_W-1:0]   cnt_q, cnt_d;
  logic [HIST_WIDTH-1:0]  entry_q [LHT_ENTRIES];

  logic                   rd_valid_q;
  logic [HIST_WIDTH-1:0]  rd_index_q;
  logic                   we_q;
  logic [HIST_WIDTH-1:0]  wt_index_q;
  logic                   brdir_q;

  logic                   idle;
  logic                   rd_accept;
  logic                   cm_accept;
  logic [LOG_LHT-1:0]     rd_idx;
  logic [LOG_LHT-1:0]     cm_idx;
  logic [HIST_WIDTH-1:0]  cm_hist_old;
  logic [HIST_WIDTH-1:0]  cm_hist_new;
  logic [HIST_WIDTH-1:0]  rd_hist;

  assign idle        = (state_q == ST_IDLE);
  assign rd_idx      = lht_index(lht_rd_pc_i);
  assign cm_idx      = lht_index(lht_cm_pc_i);
  assign rd_accept   = lht_rd_valid_i & idle & ~lht_stall_i & ~lht_flush_i;
  assign cm_accept   = lht_cm_valid_i & idle;
  // Back-to-back commits chain naturally: the table is written at the edge.
  assign cm_hist_old = entry_q[cm_idx];
  assign cm_hist_new = {cm_hist_old[HIST_WIDTH-2:0], lht_cm_brdir_i};
  // Same-cycle commit to the read index is forwarded so fetch sees the newest history.
  assign rd_hist     = (cm_accept && (cm_idx == rd_idx)) ? cm_hist_new : entry_q[rd_idx];

  assign lht_rd_ready_o     = idle;
  assign lht_cm_ready_o     = idle;
  assign lht_rd_valid_o     = rd_valid_q;
  assign lht_pht_rd_index_o = rd_index_q;
  assign lht_pht_we_o       = we_q;
  assign lht_pht_wt_index_o = wt_index_q;
  assign lht_pht_brdir_o    = brdir_q;
  assign lht_clear_busy_o   = (state_q == ST_CLEAR);

  // Clear FSM state and row-group counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM next state: sweep one row group per cycle, then back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (lht_clear_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // History table: bulk clear of the current row group, or commit shift-in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LHT_ENTRIES; i++) entry_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      for (int k = 0; k < CLR_ROWS; k++) entry_q[{cnt_q, CLR_ROW_W'(k)}] <= '0;
    end else if (cm_accept) begin
      entry_q[cm_idx] <= cm_hist_new;
    end
  end

  // Fetch output registers: flush kills, stall freezes, otherwise load on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_index_q <= '0;
    end else if (lht_flush_i) begin
      rd_valid_q <= 1'b0;
    end else if (lht_stall_i) begin
      rd_valid_q <= rd_valid_q;
    end else if (rd_accept) begin
      rd_valid_q <= 1'b1;
      rd_index_q <= rd_hist;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  // PHT write port: one-cycle pulse carrying the pre-update history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q       <= 1'b0;
      wt_index_q <= '0;
      brdir_q    <= 1'b0;
    end else begin
      we_q <= cm_accept;
      if (cm_accept) begin
        wt_index_q <= cm_hist_old;
        brdir_q    <= lht_cm_brdir_i;
      end
    end
  end

endmodule

// File: tb/tb_lht.sv
// Directed bench for the local history table.
module tb_lht;
  import lht_pkg::*;

  logic                  clock;
  logic                  reset_n;
  logic                  rd_valid_i;
  logic [PC_WIDTH-1:0]   rd_pc_i;
  logic                  rd_ready_o;
  logic                  stall_i;
  logic                  flush_i;
  logic                  rd_valid_o;
  logic [HIST_WIDTH-1:0] rd_index_o;
  logic                  cm_valid_i;
  logic [PC_WIDTH-1:0]   cm_pc_i;
  logic                  cm_brdir_i;
  logic                  cm_ready_o;
  logic                  we_o;
  logic [HIST_WIDTH-1:0] wt_index_o;
  logic                  brdir_o;
  logic                  clear_i;
  logic                  busy_o;

  int total = 0;
  int bad   = 0;

  lht dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .lht_rd_valid_i     (rd_valid_i),
    .lht_rd_pc_i        (rd_pc_i),
    .lht_rd_ready_o     (rd_ready_o),
    .lht_stall_i        (stall_i),
    .lht_flush_i        (flush_i),
    .lht_rd_valid_o     (rd_valid_o),
    .lht_pht_rd_index_o (rd_index_o),
    .lht_cm_valid_i     (cm_valid_i),
    .lht_cm_pc_i        (cm_pc_i),
    .lht_cm_brdir_i     (cm_brdir_i),
    .lht_cm_ready_o     (cm_ready_o),
    .lht_pht_we_o       (we_o),
    .lht_pht_wt_index_o (wt_index_o),
    .lht_pht_brdir_o    (brdir_o),
    .lht_clear_i        (clear_i),
    .lht_clear_busy_o   (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int  n_busy;
  bit  ready_seen;
  bit  rdv_seen;

  initial begin
    reset_n    = 1'b0;
    rd_valid_i = 1'b0;
    rd_pc_i    = '0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    cm_valid_i = 1'b0;
    cm_pc_i    = '0;
    cm_brdir_i = 1'b0;
    clear_i    = 1'b0;
    repeat (3) tick();

    check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    check("rst_rd_index", 32'(rd_index_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_wt_index", 32'(wt_index_o), 32'd0);
    check("rst_brdir", 32'(brdir_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_rd_ready", 32'(rd_ready_o), 32'd1);
    check("idle_cm_ready", 32'(cm_ready_o), 32'd1);

    // Fresh read of pc 0x1000 (index 0)
    rd_valid_i = 1'b1; rd_pc_i = 64'h1000;
    tick();
    rd_valid_i = 1'b0;
    check("rd0_valid", 32'(rd_valid_o), 32'd1);
    check("rd0_index", 32'(rd_index_o), 32'h000);
    tick();
    check("rd0_valid_drop", 32'(rd_valid_o), 32'd0);

    // Commit dirs 1,1,0 to pc 0x1000
    cm_valid_i = 1'b1; cm_pc_i = 64'h1000; cm_brdir_i = 1'b1;
    tick();
    check("cm1_we", 32'(we_o), 32'd1);
    check("cm1_wt", 32'(wt_index_o), 32'h000);
    check("cm1_dir", 32'(brdir_o), 32'd1);
    cm_brdir_i = 1'b1;
    tick();
    check("cm2_we", 32'(we_o), 32'd1);
    check("cm2_wt", 32'(wt_index_o), 32'h001);
    cm_brdir_i = 1'b0;
    tick();
    check("cm3_we", 32'(we_o), 32'd1);
    check("cm3_wt", 32'(wt_index_o), 32'h003);
    check("cm3_dir", 32'(brdir_o), 32'd0);
    cm_valid_i = 1'b0;
    rd_valid_i = 1'b1; rd_pc_i = 64'h1000;
    tick();
    rd_valid_i = 1'b0;
    check("cm_idle_we", 32'(we_o), 32'd0);
    check("rd_after_cm", 32'(rd_index_o), 32'h006);

    // Same-cycle commit and read to the same entry: bypass
    cm_valid_i = 1'b1; cm_brdir_i = 1'b1; cm_pc_i = 64'h1000;
    rd_valid_i = 1'b1; rd_pc_i = 64'h1000;
    tick();
    cm_valid_i = 1'b0; rd_valid_i = 1'b0;
    check("byp_rd_index", 32'(rd_index_o), 32'h00D);
    check("byp_wt_index", 32'(wt_index_o), 32'h006);
    check("byp_we", 32'(we_o), 32'd1);

    // Stall freezes the read registers, flush then kills valid
    rd_valid_i = 1'b1; rd_pc_i = 64'h1000;
    tick();
    rd_pc_i = 64'h2004; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), 32'(rd_valid_o), 32'd1);
      check($sformatf("stall%0d_index", i), 32'(rd_index_o), 32'h00D);
    end
    stall_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; rd_valid_i = 1'b0;
    check("flush_valid", 32'(rd_valid_o), 32'd0);
    check("flush_index", 32'(rd_index_o), 32'h00D);

    // Preload entries 1 and 0x3FF, then clear with a commit in the same cycle
    cm_valid_i = 1'b1; cm_pc_i = 64'h2004; cm_brdir_i = 1'b1;
    tick();
    cm_pc_i = 64'h3FFC;
    tick();
    cm_pc_i = 64'h2004; clear_i = 1'b1;
    tick();
    cm_valid_i = 1'b0; clear_i = 1'b0;
    check("clr_cm_we", 32'(we_o), 32'd1);
    check("clr_cm_wt", 32'(wt_index_o), 32'h001);
    rd_valid_i = 1'b1; rd_pc_i = 64'h2004;
    n_busy = 0; ready_seen = 1'b0; rdv_seen = 1'b0;
    for (int i = 0; i < 40 && busy_o; i++) begin
      n_busy++;
      if (rd_ready_o || cm_ready_o) ready_seen = 1'b1;
      if (rd_valid_o) rdv_seen = 1'b1;
      tick();
    end
    check("clr_busy_cycles", 32'(n_busy), 32'd32);
    check("clr_ready_low", 32'(ready_seen), 32'd0);
    check("clr_no_read", 32'(rdv_seen), 32'd0);
    check("clr_done_ready", 32'(rd_ready_o), 32'd1);
    tick();
    check("clr_rd_valid", 32'(rd_valid_o), 32'd1);
    check("clr_rd_index1", 32'(rd_index_o), 32'h000);
    rd_pc_i = 64'h3FFC;
    tick();
    check("clr_rd_index3ff", 32'(rd_index_o), 32'h000);
    rd_pc_i = 64'h1000;
    tick();
    rd_valid_i = 1'b0;
    check("clr_rd_index0", 32'(rd_index_o), 32'h000);

    // Reset in the middle of a clear; entry 0x3FF not yet swept when reset hits
    cm_valid_i = 1'b1; cm_pc_i = 64'h3FFC; cm_brdir_i = 1'b1;
    tick();
    cm_pc_i = 64'h1000; clear_i = 1'b1;
    tick();
    cm_valid_i = 1'b0; clear_i = 1'b0;
    repeat (10) tick();
    check("midclr_busy", 32'(busy_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_rd_valid", 32'(rd_valid_o), 32'd0);
    check("arst_we", 32'(we_o), 32'd0);
    check("arst_wt", 32'(wt_index_o), 32'd0);
    check("arst_ready", 32'(rd_ready_o), 32'd1);
    tick();
    reset_n = 1'b1;
    rd_valid_i = 1'b1; rd_pc_i = 64'h3FFC;
    tick();
    check("arst_rd3ff_valid", 32'(rd_valid_o), 32'd1);
    check("arst_rd3ff", 32'(rd_index_o), 32'h000);
    rd_pc_i = 64'h1000;
    tick();
    rd_valid_i = 1'b0;
    check("arst_rd0", 32'(rd_index_o), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lht.md
Name: lht

Overview:
- Local History Table: the stage directly upstream of the local-history PHT in the fetch unit.
- Fetch side: indexes a per-PC table of HIST_WIDTH-bit branch histories and presents the selected history, registered, as the PHT read index.
- Commit side: shifts each retired branch direction into its entry, and drives the PHT write port one cycle later with the pre-update history as the write index.
- Also provides a multi-cycle table-clear sequence (context switch / predictor invalidate).

Parameters:
- PC_WIDTH, 64, width of fetch/commit PCs
- PC_LSB, 2, lowest PC bit used for indexing (instruction alignment)
- LOG_LHT, 10, log2 of entry count
- LHT_ENTRIES, 1024, entry count (= 2**LOG_LHT)
- HIST_WIDTH, 10, history bits per entry; equals the PHT index width
- CLR_ROWS, 32, entries cleared per cycle during clear; must divide LHT_ENTRIES

Ports:
- clock, input, 1, single clock, rising edge
- reset_n, input, 1, asynchronous active-low reset
- lht_rd_valid_i, input, 1, fetch lookup request
- lht_rd_pc_i, input, PC_WIDTH, fetch PC
- lht_rd_ready_o, output, 1, lookup can be accepted
- lht_stall_i, input, 1, fetch stall: hold read output registers
- lht_flush_i, input, 1, fetch redirect: kill pending lookup
- lht_rd_valid_o, output, 1, lht_pht_rd_index_o is valid
- lht_pht_rd_index_o, output, HIST_WIDTH, history to the PHT read index
- lht_cm_valid_i, input, 1, retired conditional branch
- lht_cm_pc_i, input, PC_WIDTH, retired branch PC
- lht_cm_brdir_i, input, 1, resolved direction (1 = taken)
- lht_cm_ready_o, output, 1, commit update can be accepted
- lht_pht_we_o, output, 1, PHT write enable
- lht_pht_wt_index_o, output, HIST_WIDTH, PHT write index (pre-update history)
- lht_pht_brdir_o, output, 1, direction to the PHT
- lht_clear_i, input, 1, request a full table clear
- lht_clear_busy_o, output, 1, clear sequence in progress

Behaviour:
- Index = pc[PC_LSB+LOG_LHT-1:PC_LSB], for both read and commit.
- Reset (async, reset_n low):
  - all entries = 0
  - FSM = IDLE, clear counter = 0
  - lht_rd_valid_o = 0, lht_pht_rd_index_o = 0
  - lht_pht_we_o = 0, lht_pht_wt_index_o = 0, lht_pht_brdir_o = 0
  - lht_clear_busy_o = 0
  - A reset asserted mid-clear aborts the sequence; state returns to IDLE with the table zeroed.
- Ready signals: lht_rd_ready_o = lht_cm_ready_o = (FSM == IDLE), combinational.
- Read path, 1-cycle latency:
  - Accept = rd_valid_i & rd_ready_o & !stall_i & !flush_i.
  - On accept, next cycle: rd_valid_o = 1 and rd_index_o = entry history.
  - If lht_stall_i: both output registers hold their values. Stall has priority over everything except reset and flush.
  - If lht_flush_i: rd_valid_o = 0 next cycle; rd_index_o holds.
  - Otherwise (no accept): rd_valid_o = 0 next cycle.
- Commit path:
  - On accept (cm_valid_i & cm_ready_o), the entry becomes {hist[HIST_WIDTH-2:0], brdir} at the edge.
  - Next cycle, for exactly one cycle: pht_we_o = 1, pht_wt_index_o = pre-update history, pht_brdir_o = brdir.
  - pht_we_o = 0 in every cycle not following a commit accept.
- Bypass:
  - A read accepted in the same cycle as a commit to the same index returns the post-update history.
  - Back-to-back commits to the same index chain: the second uses the first's result.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when lht_clear_i = 1. A commit accepted in that same cycle still updates its entry and emits its PHT write.
  - CLEAR: each cycle zero rows [cnt*CLR_ROWS, cnt*CLR_ROWS+CLR_ROWS-1], then increment cnt.
  - At cnt = LHT_ENTRIES/CLR_ROWS-1: clear the final rows, reset cnt to 0, return to IDLE.
  - lht_clear_busy_o = (FSM == CLEAR): high for exactly LHT_ENTRIES/CLR_ROWS cycles (32 at defaults).
  - lht_clear_i is ignored while in CLEAR.
  - No reads or commits are accepted during CLEAR. Upstream must hold valid; no request is dropped.
- Width rules:
  - Counter width = log2(LHT_ENTRIES/CLR_ROWS).
  - The history shift discards the MSB; no other arithmetic.

Decomposition:
- Shared fetch package:
  - LOG_LHT, HIST_WIDTH and PC_LSB constants (kept consistent with the PHT's LOG_INDEX)
  - clear FSM state encoding: IDLE = 1'b0, CLEAR = 1'b1
  - index-extract function
- No sub-module; the entry array, read register, commit register and clear FSM live in one module.

Test Plan:
- Reset, then read pc 0x1000 -> next cycle rd_valid_o = 1, rd_index_o = 0x000.
- Commit pc 0x1000 with dirs 1,1,0 on consecutive cycles:
  - pht_wt_index_o = 0x000, 0x001, 0x003 on consecutive cycles, we_o = 1 each
  - a subsequent read returns 0x006
- Commit dir 1 and read the same pc (history 0x006) in the same cycle -> read returns 0x00D; pht_wt_index_o = 0x006.
- Read accepted, then stall_i held 3 cycles -> rd_valid_o / rd_index_o frozen. Then flush_i -> rd_valid_o = 0 next cycle.
- Preload several entries, then pulse clear_i:
  - busy_o high for exactly 32 cycles; both ready signals low throughout
  - a read held valid during clear is accepted the first IDLE cycle and returns 0
- Assert reset_n low at clear cycle 10 -> busy_o = 0 immediately, all outputs 0; after release, reads return 0.
